// File: rtl/reg_rename_file_if.sv
// Issue/ROB-side bundle for reg_rename_file: read ports, rename, commit, flush and stall.
// master = issue stage / ROB driving requests, slave = the register file.
interface reg_rename_file_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned ROB_BITS = 4,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NCM      = 2
);
    localparam int unsigned IDX_W = $clog2(NREG);

    logic                    rdy_in;
    logic                    rob_clear;
    logic [NRD*IDX_W-1:0]    rd_idx;
    logic [NRD*XLEN-1:0]     rd_val;
    logic [NRD-1:0]          rd_has_dep;
    logic [NRD*ROB_BITS-1:0] rd_tag;
    logic                    rn_valid;
    logic [IDX_W-1:0]        rn_idx;
    logic [ROB_BITS-1:0]     rn_tag;
    logic [NCM-1:0]          cm_valid;
    logic [NCM*IDX_W-1:0]    cm_idx;
    logic [NCM*XLEN-1:0]     cm_val;
    logic [NCM*ROB_BITS-1:0] cm_tag;
    logic [IDX_W:0]          pending_cnt;

    modport master (
        output rdy_in, rob_clear, rd_idx, rn_valid, rn_idx, rn_tag,
               cm_valid, cm_idx, cm_val, cm_tag,
        input  rd_val, rd_has_dep, rd_tag, pending_cnt
    );

    modport slave (
        input  rdy_in, rob_clear, rd_idx, rn_valid, rn_idx, rn_tag,
               cm_valid, cm_idx, cm_val, cm_tag,
        output rd_val, rd_has_dep, rd_tag, pending_cnt
    );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags, NRD reads and NCM commits.
// Define REGFILE_BYPASS_EN to forward same-cycle commits onto the read ports.
module reg_rename_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned ROB_BITS = 4,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NCM      = 2
) (
    input logic              clk_in,
    input logic              rst_in,
    reg_rename_file_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NREG);

    logic [XLEN-1:0]     r_val [NREG];
    logic [ROB_BITS-1:0] r_tag [NREG];
    logic [NREG-1:0]     r_dep;
    logic [IDX_W:0]      r_cnt;

    logic [XLEN-1:0]     w_val_d [NREG];
    logic [ROB_BITS-1:0] w_tag_d [NREG];
    logic [NREG-1:0]     w_dep_d;
    logic [IDX_W:0]      w_cnt_d;

    logic [IDX_W-1:0]    w_cm_idx [NCM];
    logic [XLEN-1:0]     w_cm_val [NCM];
    logic [ROB_BITS-1:0] w_cm_tag [NCM];
    logic [IDX_W-1:0]    w_rd_idx [NRD];

    always_comb begin
        for (int unsigned c = 0; c < NCM; c++) begin
            w_cm_idx[c] = bus.cm_idx[c*IDX_W +: IDX_W];
            w_cm_val[c] = bus.cm_val[c*XLEN +: XLEN];
            w_cm_tag[c] = bus.cm_tag[c*ROB_BITS +: ROB_BITS];
        end
        for (int unsigned k = 0; k < NRD; k++) begin
            w_rd_idx[k] = bus.rd_idx[k*IDX_W +: IDX_W];
        end
    end

    always_comb begin
        w_val_d = r_val;
        w_tag_d = r_tag;
        w_dep_d = r_dep;
        // Ascending port order lets the youngest commit win the value write.
        for (int unsigned c = 0; c < NCM; c++) begin
            if (bus.cm_valid[c] && w_cm_idx[c] != '0) begin
                w_val_d[w_cm_idx[c]] = w_cm_val[c];
                if (r_dep[w_cm_idx[c]] && r_tag[w_cm_idx[c]] == w_cm_tag[c]) begin
                    w_dep_d[w_cm_idx[c]] = 1'b0;
                    w_tag_d[w_cm_idx[c]] = '0;
                end
            end
        end
        if (bus.rob_clear) begin
            w_dep_d = '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                w_tag_d[i] = '0;
            end
        end else if (bus.rn_valid && bus.rn_idx != '0) begin
            w_tag_d[bus.rn_idx] = bus.rn_tag;
            w_dep_d[bus.rn_idx] = 1'b1;
        end
        w_cnt_d = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            w_cnt_d = w_cnt_d + (IDX_W+1)'(w_dep_d[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
            r_dep <= '0;
            r_cnt <= '0;
        end else if (bus.rdy_in) begin
            r_val <= w_val_d;
            r_tag <= w_tag_d;
            r_dep <= w_dep_d;
            r_cnt <= w_cnt_d;
        end
    end

    always_comb begin
        bus.rd_val     = '0;
        bus.rd_has_dep = '0;
        bus.rd_tag     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            bus.rd_val[k*XLEN +: XLEN]         = r_val[w_rd_idx[k]];
            bus.rd_has_dep[k]                  = r_dep[w_rd_idx[k]];
            bus.rd_tag[k*ROB_BITS +: ROB_BITS] = r_tag[w_rd_idx[k]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned c = 0; c < NCM; c++) begin
                if (bus.cm_valid[c] && w_cm_idx[c] == w_rd_idx[k] && w_rd_idx[k] != '0) begin
                    bus.rd_val[k*XLEN +: XLEN] = w_cm_val[c];
                    bus.rd_has_dep[k] = r_dep[w_rd_idx[k]] && (w_cm_tag[c] != r_tag[w_rd_idx[k]]);
                end
            end
`endif
        end
    end

    assign bus.pending_cnt = r_cnt;
endmodule
